// File: rtl/iob_rs232_tx_arbiter_if.sv
// Byte-stream bundle between two console requesters, the arbiter and the UART TX port.
// Signal names carry the arbiter's view (_i into the arbiter, _o out of it).
//   req0_*/req1_* : requester byte streams (valid/data/last in, ready out)
//   tx_*          : registered output byte stream towards the UART (ready in)
//   cts_i         : link clear-to-send
//   grant_o       : one-hot current grant
//   timeout_o     : one-cycle pulse when a grant is revoked for inactivity
// Modports: master = requester/UART side, slave = arbiter.
interface iob_rs232_tx_arbiter_if #(
   parameter int unsigned DATA_W = 8
);
   logic              req0_valid_i;
   logic [DATA_W-1:0] req0_data_i;
   logic              req0_last_i;
   logic              req0_ready_o;
   logic              req1_valid_i;
   logic [DATA_W-1:0] req1_data_i;
   logic              req1_last_i;
   logic              req1_ready_o;
   logic              tx_valid_o;
   logic [DATA_W-1:0] tx_data_o;
   logic              tx_ready_i;
   logic              cts_i;
   logic [1:0]        grant_o;
   logic              timeout_o;

   modport master (
      output req0_valid_i, req0_data_i, req0_last_i,
      output req1_valid_i, req1_data_i, req1_last_i,
      output tx_ready_i, cts_i,
      input  req0_ready_o, req1_ready_o, tx_valid_o, tx_data_o, grant_o, timeout_o
   );

   modport slave (
      input  req0_valid_i, req0_data_i, req0_last_i,
      input  req1_valid_i, req1_data_i, req1_last_i,
      input  tx_ready_i, cts_i,
      output req0_ready_o, req1_ready_o, tx_valid_o, tx_data_o, grant_o, timeout_o
   );
endinterface

// File: rtl/iob_rs232_tx_arbiter.sv
// Shares one RS232 transmit path between two byte-stream requesters. Whole messages are
// granted round-robin, optionally prefixed with a per-requester tag byte, through a single
// registered output byte buffer that honours UART ready and link CTS.
// Ports:
//   clk_i    : system clock
//   arst_n_i : asynchronous reset, active-low
//   cke_i    : clock enable; low freezes all state and forces ready outputs low
//   bus      : requester/UART/grant bundle (slave modport)
module iob_rs232_tx_arbiter #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       TIMEOUT_W = 16,
   parameter int unsigned       TIMEOUT   = 1000,
   parameter bit                TAG_EN    = 1'b1,
   parameter logic [DATA_W-1:0] TAG0      = DATA_W'(8'h01),
   parameter logic [DATA_W-1:0] TAG1      = DATA_W'(8'h02)
) (
   input logic                    clk_i,
   input logic                    arst_n_i,
   input logic                    cke_i,
   iob_rs232_tx_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StHeader, StStream} state_e;

   state_e               state_q, state_d;
   logic [1:0]           grant_q, grant_d;
   logic                 last_id_q, last_id_d;   // requester that ended the latest message
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                 tx_valid_q, tx_valid_d;
   logic [DATA_W-1:0]    tx_data_q, tx_data_d;
   logic                 timeout_q, timeout_d;

   logic                 out_xfer, out_free;
   logic                 ready0, ready1, accept;
   logic                 gnt_id, gnt_valid, gnt_last;
   logic [DATA_W-1:0]    gnt_data;
   logic [TIMEOUT_W-1:0] cnt_inc;
   logic                 pick;

   // Handshake decode; ready depends only on state and the output side, never on valid.
   always_comb begin
      out_xfer  = tx_valid_q & bus.tx_ready_i & bus.cts_i & cke_i;
      out_free  = ~tx_valid_q | out_xfer;
      ready0    = cke_i & (state_q == StStream) & grant_q[0] & out_free;
      ready1    = cke_i & (state_q == StStream) & grant_q[1] & out_free;
      accept    = (bus.req0_valid_i & ready0) | (bus.req1_valid_i & ready1);
      gnt_id    = grant_q[1];
      gnt_valid = gnt_id ? bus.req1_valid_i : bus.req0_valid_i;
      gnt_last  = gnt_id ? bus.req1_last_i  : bus.req0_last_i;
      gnt_data  = gnt_id ? bus.req1_data_i  : bus.req0_data_i;
      cnt_inc   = cnt_q + TIMEOUT_W'(1);
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_id_d  = last_id_q;
      cnt_d      = cnt_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      timeout_d  = timeout_q;
      pick       = 1'b0;

      if (cke_i) begin
         timeout_d = 1'b0;
         // Drain first; a load below overrides the clear in the same cycle.
         if (out_xfer) begin
            tx_valid_d = 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (bus.req0_valid_i | bus.req1_valid_i) begin
                  // On contention prefer the requester that did not finish last.
                  pick    = (bus.req0_valid_i & bus.req1_valid_i) ? ~last_id_q
                                                                  : bus.req1_valid_i;
                  grant_d = pick ? 2'b10 : 2'b01;
                  cnt_d   = '0;
                  state_d = TAG_EN ? StHeader : StStream;
               end
            end

            StHeader: begin
               if (out_free) begin
                  tx_valid_d = 1'b1;
                  tx_data_d  = gnt_id ? TAG1 : TAG0;
                  state_d    = StStream;
               end
            end

            StStream: begin
               if (accept) begin
                  tx_valid_d = 1'b1;
                  tx_data_d  = gnt_data;
                  cnt_d      = '0;
                  if (gnt_last) begin
                     state_d   = StIdle;
                     grant_d   = 2'b00;
                     last_id_d = gnt_id;
                  end
               end else if (!gnt_valid) begin
                  // Only true inactivity counts; backpressured valid bytes do not.
                  if (cnt_inc == TIMEOUT_W'(TIMEOUT)) begin
                     timeout_d = 1'b1;
                     state_d   = StIdle;
                     grant_d   = 2'b00;
                     last_id_d = gnt_id;
                     cnt_d     = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end

            default: begin
               state_d = StIdle;
               grant_d = 2'b00;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= StIdle;
         grant_q    <= 2'b00;
         last_id_q  <= 1'b1;   // so requester 0 wins the first contention
         cnt_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_id_q  <= last_id_d;
         cnt_q      <= cnt_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.req0_ready_o = ready0;
   assign bus.req1_ready_o = ready1;
   assign bus.tx_valid_o   = tx_valid_q;
   assign bus.tx_data_o    = tx_data_q;
   assign bus.grant_o      = grant_q;
   assign bus.timeout_o    = timeout_q;

endmodule
